// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage sequencer behind the EX/MEM pipeline register. Non-memory
// instructions pass straight to the MEM/WB registers with no added latency.
// Loads and stores get a single-cycle request strobe to a multi-cycle data
// memory. The upstream pipeline is stalled until the access completes or the
// watchdog aborts it.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   MEM_MemRead/MemWrite         access type of the instruction in MEM
//   MEM_MemtoReg/RegWrite        writeback controls carried to WB
//   MEM_ALUval, MEM_StoreData    address / ALU result, store data
//   mem_en, mem_wr, mem_addr,    registered request to the data memory
//   mem_wdata
//   mem_ready, mem_rdata         single-cycle completion pulse and read data
//   stall                        holds the upstream pipeline registers
//   WB_RegWrite, WB_MemtoReg,    registered values for the writeback stage
//   WB_ALUval, WB_MemData
//   mem_err                      one-cycle error pulse: read+write conflict,
//                                watchdog timeout, or misaligned access
//
// Optional feature: define MEM_ALIGN_CHK_EN to reject accesses to odd
// addresses. A rejected access is not issued to memory, and its register
// write is suppressed.
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic              MEM_MemtoReg,
   input  logic              MEM_RegWrite,
   input  logic [DATA_W-1:0] MEM_ALUval,
   input  logic [DATA_W-1:0] MEM_StoreData,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              WB_RegWrite,
   output logic              WB_MemtoReg,
   output logic [DATA_W-1:0] WB_ALUval,
   output logic [DATA_W-1:0] WB_MemData,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Last wait-counter value before the watchdog fires. The counter starts
   // at 0 in the first WAIT cycle, so this gives exactly TIMEOUT WAIT cycles.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_wr_q, mem_wr_d;
   logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                sh_regwrite_q, sh_regwrite_d;
   logic                sh_memtoreg_q, sh_memtoreg_d;
   logic [DATA_W-1:0]   sh_aluval_q, sh_aluval_d;
   logic [DATA_W-1:0]   cap_data_q, cap_data_d;
   logic                wb_regwrite_q, wb_regwrite_d;
   logic                wb_memtoreg_q, wb_memtoreg_d;
   logic [DATA_W-1:0]   wb_aluval_q, wb_aluval_d;
   logic [DATA_W-1:0]   wb_memdata_q, wb_memdata_d;
   logic                stall_s;
   logic                err_s;
   logic                access_s;
   logic                conflict_s;
   logic                misalign_s;

   assign access_s   = MEM_MemRead | MEM_MemWrite;
   assign conflict_s = MEM_MemRead & MEM_MemWrite;

`ifdef MEM_ALIGN_CHK_EN
   assign misalign_s = access_s & MEM_ALUval[0];
`else
   assign misalign_s = 1'b0;
`endif

   // Next-state, request latch, shadow copy and writeback update logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_wr_d      = mem_wr_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      sh_regwrite_d = sh_regwrite_q;
      sh_memtoreg_d = sh_memtoreg_q;
      sh_aluval_d   = sh_aluval_q;
      cap_data_d    = cap_data_q;
      wb_regwrite_d = wb_regwrite_q;
      wb_memtoreg_d = wb_memtoreg_q;
      wb_aluval_d   = wb_aluval_q;
      wb_memdata_d  = wb_memdata_q;
      stall_s       = 1'b0;
      err_s         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (access_s) begin
               stall_s       = 1'b1;
               err_s         = conflict_s | misalign_s;
               sh_memtoreg_d = MEM_MemtoReg;
               sh_aluval_d   = MEM_ALUval;
               cap_data_d    = {DATA_W{1'b0}};
               cnt_d         = 8'd0;
               if (misalign_s) begin
                  // Rejected: skip the memory and kill the register write.
                  sh_regwrite_d = 1'b0;
                  state_d       = ST_DONE;
               end else begin
                  // A read+write conflict is performed as a write.
                  sh_regwrite_d = MEM_RegWrite;
                  mem_wr_d      = MEM_MemWrite;
                  mem_addr_d    = MEM_ALUval;
                  mem_wdata_d   = MEM_StoreData;
                  state_d       = ST_REQ;
               end
            end else begin
               wb_regwrite_d = MEM_RegWrite;
               wb_memtoreg_d = MEM_MemtoReg;
               wb_aluval_d   = MEM_ALUval;
               wb_memdata_d  = {DATA_W{1'b0}};
            end
         end
         ST_REQ: begin
            stall_s = 1'b1;
            if (mem_ready) begin
               cap_data_d = mem_wr_q ? {DATA_W{1'b0}} : mem_rdata;
               state_d    = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            if (mem_ready) begin
               cap_data_d = mem_wr_q ? {DATA_W{1'b0}} : mem_rdata;
               state_d    = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_s      = 1'b1;
               cap_data_d = {DATA_W{1'b0}};
               state_d    = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            // stall is low here, so upstream advances on this same edge and
            // the finished access is never seen again in IDLE.
            wb_regwrite_d = sh_regwrite_q;
            wb_memtoreg_d = sh_memtoreg_q;
            wb_aluval_d   = sh_aluval_q;
            wb_memdata_d  = cap_data_q;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The strobe is registered and raised only for the cycle spent in REQ.
      mem_en_d = (state_d == ST_REQ);
   end

   // State, request, shadow and writeback registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 8'd0;
         mem_en_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_addr_q    <= {DATA_W{1'b0}};
         mem_wdata_q   <= {DATA_W{1'b0}};
         sh_regwrite_q <= 1'b0;
         sh_memtoreg_q <= 1'b0;
         sh_aluval_q   <= {DATA_W{1'b0}};
         cap_data_q    <= {DATA_W{1'b0}};
         wb_regwrite_q <= 1'b0;
         wb_memtoreg_q <= 1'b0;
         wb_aluval_q   <= {DATA_W{1'b0}};
         wb_memdata_q  <= {DATA_W{1'b0}};
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_en_q      <= mem_en_d;
         mem_wr_q      <= mem_wr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         sh_regwrite_q <= sh_regwrite_d;
         sh_memtoreg_q <= sh_memtoreg_d;
         sh_aluval_q   <= sh_aluval_d;
         cap_data_q    <= cap_data_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_memtoreg_q <= wb_memtoreg_d;
         wb_aluval_q   <= wb_aluval_d;
         wb_memdata_q  <= wb_memdata_d;
      end
   end

   assign mem_en      = mem_en_q;
   assign mem_wr      = mem_wr_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign WB_RegWrite = wb_regwrite_q;
   assign WB_MemtoReg = wb_memtoreg_q;
   assign WB_ALUval   = wb_aluval_q;
   assign WB_MemData  = wb_memdata_q;
   // stall and mem_err must act in the cycle that detects the condition, so
   // they stay combinational.
   assign stall       = stall_s;
   assign mem_err     = err_s;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
   localparam int DW = 16;
   localparam int TO = 15;
   localparam int NEVER = 99;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
   logic [DW-1:0] MEM_ALUval, MEM_StoreData;
   logic          mem_en, mem_wr;
   logic [DW-1:0] mem_addr, mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          stall, WB_RegWrite, WB_MemtoReg, mem_err;
   logic [DW-1:0] WB_ALUval, WB_MemData;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
      .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
      .MEM_ALUval(MEM_ALUval), .MEM_StoreData(MEM_StoreData),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
      .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
      .WB_ALUval(WB_ALUval), .WB_MemData(WB_MemData), .mem_err(mem_err)
   );

   int checks = 0;
   int errors = 0;

   // Expected WB contents left behind by the previous instruction.
   logic          prev_rw, prev_m2r;
   logic [DW-1:0] prev_alu, prev_md;

   typedef struct {
      logic          rd, wr, rw, m2r;
      logic [DW-1:0] alu, sdata, rdata;
      int            dly;          // cycles after the mem_en cycle until mem_ready
      logic          e_rw, e_m2r;
      logic [DW-1:0] e_alu, e_md;
      int            e_stall;      // cycles with stall = 1
      int            e_en;         // cycles with mem_en = 1
      int            e_err;        // cycles with mem_err = 1
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, wr, rw, m2r, input logic [DW-1:0] alu, sdata,
                               rdata, input int dly, input logic e_rw, e_m2r,
                               input logic [DW-1:0] e_alu, e_md, input int e_stall, e_en, e_err);
      vec_t v;
      v.rd = rd; v.wr = wr; v.rw = rw; v.m2r = m2r;
      v.alu = alu; v.sdata = sdata; v.rdata = rdata; v.dly = dly;
      v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_alu = e_alu; v.e_md = e_md;
      v.e_stall = e_stall; v.e_en = e_en; v.e_err = e_err;
      return v;
   endfunction

   // Transaction-level reference: expected cycle counts and WB values from
   // the access rules (latency = IDLE + REQ + waits + DONE).
   function automatic vec_t model(input vec_t v);
      vec_t r;
      bit acc, mis, conf, ok;
      r    = v;
      acc  = v.rd | v.wr;
      conf = v.rd & v.wr;
      mis  = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
      mis  = acc & v.alu[0];
`endif
      ok   = (v.dly >= 0) && (v.dly <= TO);
      r.e_m2r = v.m2r;
      r.e_alu = v.alu;
      if (!acc) begin
         r.e_rw = v.rw; r.e_md = '0; r.e_stall = 0; r.e_en = 0; r.e_err = 0;
      end else if (mis) begin
         r.e_rw = 1'b0; r.e_md = '0; r.e_stall = 1; r.e_en = 0; r.e_err = 1;
      end else if (ok) begin
         r.e_rw = v.rw; r.e_md = v.wr ? '0 : v.rdata;
         r.e_stall = 2 + v.dly; r.e_en = 1; r.e_err = conf ? 1 : 0;
      end else begin
         r.e_rw = v.rw; r.e_md = '0;
         r.e_stall = 2 + TO; r.e_en = 1; r.e_err = (conf ? 1 : 0) + 1;
      end
      return r;
   endfunction

   // Drives one instruction until it leaves the stage, acting as the memory.
   // Entered and left at 1 time unit after a rising edge.
   task automatic run_vec(input vec_t v, input string tag);
      int  en_cyc, n_stall, n_en, n_err;
      bit  done;
      en_cyc = -1; n_stall = 0; n_en = 0; n_err = 0; done = 1'b0;
      MEM_MemRead = v.rd; MEM_MemWrite = v.wr; MEM_RegWrite = v.rw; MEM_MemtoReg = v.m2r;
      MEM_ALUval = v.alu; MEM_StoreData = v.sdata; mem_rdata = v.rdata;
      for (int c = 0; c < 40 && !done; c++) begin
         if (mem_en === 1'b1) begin
            n_en++;
            if (en_cyc < 0) en_cyc = c;
            chk({tag, " mem_wr"}, {31'd0, mem_wr}, {31'd0, v.wr});
            chk({tag, " mem_addr"}, {16'd0, mem_addr}, {16'd0, v.alu});
            chk({tag, " mem_wdata"}, {16'd0, mem_wdata}, {16'd0, v.sdata});
         end
         if (!(v.rd | v.wr)) mem_ready = 1'($urandom_range(0, 1)); // must be ignored
         else mem_ready = (en_cyc >= 0 && (c - en_cyc) == v.dly);
         @(negedge clk);
         if (stall === 1'b1) n_stall++;
         if (mem_err === 1'b1) n_err++;
         if (stall !== 1'b1) begin
            done = 1'b1;
            chk({tag, " WB held"}, {15'd0, WB_RegWrite, WB_ALUval}, {15'd0, prev_rw, prev_alu});
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: stall never dropped within 40 cycles", tag);
      end
      chk({tag, " stall cycles"}, n_stall, v.e_stall);
      chk({tag, " mem_en cycles"}, n_en, v.e_en);
      chk({tag, " mem_err cycles"}, n_err, v.e_err);
      chk({tag, " WB_RegWrite"}, {31'd0, WB_RegWrite}, {31'd0, v.e_rw});
      chk({tag, " WB_MemtoReg"}, {31'd0, WB_MemtoReg}, {31'd0, v.e_m2r});
      chk({tag, " WB_ALUval"}, {16'd0, WB_ALUval}, {16'd0, v.e_alu});
      chk({tag, " WB_MemData"}, {16'd0, WB_MemData}, {16'd0, v.e_md});
      prev_rw = v.e_rw; prev_m2r = v.e_m2r; prev_alu = v.e_alu; prev_md = v.e_md;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " mem_en"}, {31'd0, mem_en}, 32'd0);
      chk({tag, " mem_wr"}, {31'd0, mem_wr}, 32'd0);
      chk({tag, " mem_addr"}, {16'd0, mem_addr}, 32'd0);
      chk({tag, " mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
      chk({tag, " stall"}, {31'd0, stall}, 32'd0);
      chk({tag, " mem_err"}, {31'd0, mem_err}, 32'd0);
      chk({tag, " WB"}, {14'd0, WB_RegWrite, WB_MemtoReg, WB_ALUval}, 32'd0);
      chk({tag, " WB_MemData"}, {16'd0, WB_MemData}, 32'd0);
   endtask

   initial begin
      vec_t v;
      int   wait_cyc;

      //            rd    wr    rw    m2r   alu       sdata     rdata     dly    e_rw  e_m2r e_alu     e_md    st en er
      tbl[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0,     1'b1, 1'b0, 16'h1234, 16'h0000, 0, 0, 0);
      tbl[1] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 2,     1'b1, 1'b1, 16'h0040, 16'hBEEF, 4, 1, 0);
      tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h00AA, 16'h5555, 1,     1'b0, 1'b0, 16'h0010, 16'h0000, 3, 1, 0);
      tbl[3] = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h1111, 16'h0000, 0,     1'b0, 1'b1, 16'hFFFF, 16'h0000, 0, 0, 0);
      tbl[4] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000, 16'h1357, 0,     1'b1, 1'b1, 16'h0100, 16'h1357, 2, 1, 0);
      tbl[5] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0000, 16'hDEAD, NEVER, 1'b1, 1'b1, 16'h0200, 16'h0000, 17, 1, 1);
      tbl[6] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h0000, 16'hA5A5, 15,    1'b1, 1'b1, 16'h0300, 16'hA5A5, 17, 1, 0);
      tbl[7] = mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0400, 16'h7777, 16'h9999, 1,     1'b1, 1'b0, 16'h0400, 16'h0000, 3, 1, 1);
`ifdef MEM_ALIGN_CHK_EN
      tbl[8] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0041, 16'h0000, 16'h4242, 1,     1'b0, 1'b1, 16'h0041, 16'h0000, 1, 0, 1);
`else
      tbl[8] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0041, 16'h0000, 16'h4242, 1,     1'b1, 1'b1, 16'h0041, 16'h4242, 3, 1, 0);
`endif

      rst_n = 1'b0;
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b0; MEM_MemtoReg = 1'b0;
      MEM_ALUval = '0; MEM_StoreData = '0; mem_ready = 1'b0; mem_rdata = '0;
      prev_rw = 1'b0; prev_m2r = 1'b0; prev_alu = '0; prev_md = '0;
      #12;
      chk_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Store followed by a non-memory op: the store must not be reissued.
      run_vec(tbl[2], "store");
      run_vec(tbl[0], "after store");

      // Reset asserted while the access is in WAIT, then a late mem_ready.
      MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b1; MEM_MemtoReg = 1'b1;
      MEM_ALUval = 16'h0080; MEM_StoreData = 16'h3C3C; mem_rdata = 16'h6666;
      wait_cyc = 0;
      while (mem_en !== 1'b1 && wait_cyc < 10) begin
         @(posedge clk); #1; wait_cyc++;
      end
      chk("rst-mid mem_en seen", {31'd0, mem_en}, 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      MEM_MemRead = 1'b0; MEM_RegWrite = 1'b0; MEM_MemtoReg = 1'b0;
      MEM_ALUval = '0; MEM_StoreData = '0;
      #1;
      chk_all_zero("rst-mid");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1; mem_ready = 1'b1;
      @(negedge clk);
      chk("rst-mid late ready mem_err", {31'd0, mem_err}, 32'd0);
      chk("rst-mid late ready stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1; mem_ready = 1'b0;
      @(negedge clk);
      chk("rst-mid mem_en after", {31'd0, mem_en}, 32'd0);
      chk("rst-mid WB_MemData after", {16'd0, WB_MemData}, 32'd0);
      @(posedge clk); #1;
      prev_rw = 1'b0; prev_m2r = 1'b0; prev_alu = '0; prev_md = '0;

      // Randomized instructions checked against the reference model.
      for (int i = 0; i < 60; i++) begin
         int k;
         k = int'($urandom_range(0, 3));
         v.rd    = (k == 1) || (k == 3);
         v.wr    = (k == 2) || (k == 3 && $urandom_range(0, 1) == 1);
         v.rw    = 1'($urandom_range(0, 1));
         v.m2r   = 1'($urandom_range(0, 1));
         v.alu   = 16'($urandom);
         v.sdata = 16'($urandom);
         v.rdata = 16'($urandom);
         v.dly   = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, TO + 3));
         v = model(v);
         run_vec(v, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
